versatile_fifo_dual_port_ram_sc_be: RTL and testbench
=====================================================

Name: versatile_fifo_dual_port_ram_sc_be

Overview:
Single-clock true dual-port RAM, next generation of the FIFO storage primitive. Adds per-lane byte enables, separate read and write strobes, a selectable read-during-write mode and an optional registered output stage with valid tracking. Detects same-address write collisions between the two ports. Sits under the FIFO controllers and packet buffers as their generic storage element.

Parameters:
DATA_WIDTH, 32, word width; must be an integer multiple of BYTE_WIDTH
BYTE_WIDTH, 8, width of one byte lane; BE_WIDTH = DATA_WIDTH/BYTE_WIDTH (localparam)
ADDR_WIDTH, 9, address width; depth = 2**ADDR_WIDTH
RDW_MODE, 0, same-port read-during-write: 0 = new data (write-first), 1 = old data (read-first)
OUT_REG, 0, 0 = q valid 1 cycle after access; 1 = extra output register, q valid 2 cycles after access
CNT_WIDTH, 8, width of collision counter (optional feature only)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
d_a  in  DATA_WIDTH  port A write data
be_a  in  BE_WIDTH  port A byte enables (write only)
adr_a  in  ADDR_WIDTH  port A address
we_a  in  1  port A write strobe
re_a  in  1  port A read strobe
q_a  out  DATA_WIDTH  port A read data
vld_a  out  1  q_a holds data of a completed access
d_b, be_b, adr_b, we_b, re_b, q_b, vld_b  same as port A, for port B
coll  out  1  sticky: both ports wrote the same address with overlapping byte enables
coll_clr  in  1  synchronous clear of coll (and counter)

Behaviour:
- Reset: q_a, q_b = 0; vld_a, vld_b = 0; coll = 0; pipeline registers = 0. RAM contents are not reset and stay undefined.
- Access on a port = we_x | re_x. Accesses are single-cycle with no backpressure; one access per port per cycle.
- Write: for each lane i with be_x[i]=1, ram[adr_x] lane i <= d_x lane i. Other lanes are unchanged. we_x with be_x=0 writes nothing but still counts as an access.
- Read data, same port:
  - Word is ram[adr_x] as of the access cycle.
  - If we_x and RDW_MODE=0, returned lanes with be_x set carry d_x; remaining lanes carry old contents.
  - If RDW_MODE=1, all lanes return old contents.
- Cross-port read of an address being written by the other port in the same cycle always returns old contents.
- Write-write, same address, same cycle: per lane, port A wins where be_a set; port B lanes land where only be_b set. coll sets the cycle after iff (be_a & be_b) != 0.
- coll_clr=1 clears coll next cycle. A new collision in the same cycle as coll_clr wins, so coll = 1.
- Latency:
  - OUT_REG=0: q_x and vld_x update the cycle after the access. vld_x = 1 for exactly the cycles following an access. q_x holds its last value when there is no access.
  - OUT_REG=1: one further stage; vld_x is delayed with q_x.
- rst_n asserted mid-operation: outputs and pipeline clear immediately. An in-flight write at the reset edge is not guaranteed to complete.
- Elaboration check: DATA_WIDTH % BYTE_WIDTH != 0 is an error ($error / generate trap).

Optional Feature:
- Macro: VERSATILE_FIFO_RAM_COLL_CNT_EN.
- Defined: adds output coll_cnt [CNT_WIDTH-1:0].
  - Counts collision cycles and saturates at all-ones.
  - coll_clr zeroes it; a collision in the same cycle as coll_clr loads 1.
  - Resets to 0.
- Undefined: port and counter absent; coll behaviour unchanged.

Test Plan:
1. DATA 32/BYTE 8/ADDR 4, OUT_REG=0. Write A adr 3 = 0x11223344, be 0xF; next cycle re_a adr 3 -> q_a = 0x11223344 and vld_a = 1 one cycle after the read.
2. Partial write B adr 3 d=0xAABBCCDD be=0x5, with RDW_MODE=0 -> q_b = 0x11BB33DD in the same-port response; a later read of adr 3 returns 0x11BB33DD. Repeat with RDW_MODE=1 -> response 0x11223344.
3. Same cycle: A writes adr 5 0xFFFFFFFF be 0x3, B writes adr 5 0x00000000 be 0x6 -> adr 5 lanes 0,1 = 0xFF, lane 2 = 0x00; coll = 1. Assert coll_clr with no collision -> coll = 0. Assert coll_clr with a new collision -> coll stays 1.
4. A writes adr 7 0xDEADBEEF while B reads adr 7 in the same cycle -> q_b = previous contents of adr 7; a B read the next cycle -> 0xDEADBEEF.
5. OUT_REG=1: read A adr 3 at cycle n -> vld_a and q_a appear at n+2. Back-to-back reads of adr 0..3 stream with one result per cycle.
6. Assert rst_n low mid-stream -> q_a, q_b, vld_a, vld_b, coll go to 0 without waiting for a clock edge. With VERSATILE_FIFO_RAM_COLL_CNT_EN and CNT_WIDTH=2, five collisions -> coll_cnt = 3.

Source files
------------

// File: rtl/versatile_fifo_dual_port_ram_sc_be.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write and optional output register.
// Define VERSATILE_FIFO_RAM_COLL_CNT_EN to add the saturating collision counter output coll_cnt.
module versatile_fifo_dual_port_ram_sc_be #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 8,
    localparam int BE_WIDTH  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] d_a,
    input  logic [BE_WIDTH-1:0]   be_a,
    input  logic [ADDR_WIDTH-1:0] adr_a,
    input  logic                  we_a,
    input  logic                  re_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  vld_a,
    input  logic [DATA_WIDTH-1:0] d_b,
    input  logic [BE_WIDTH-1:0]   be_b,
    input  logic [ADDR_WIDTH-1:0] adr_b,
    input  logic                  we_b,
    input  logic                  re_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  vld_b,
    output logic                  coll,
    input  logic                  coll_clr
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  coll_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % BYTE_WIDTH) != 0 || CNT_WIDTH < 1) begin : g_bad_params
            $error("versatile_fifo_dual_port_ram_sc_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_d, rdata_b_d;
    logic [DATA_WIDTH-1:0] q1_a_q, q1_b_q;
    logic                  v1_a_q, v1_b_q;
    logic                  acc_a, acc_b;
    logic                  coll_hit;
    logic                  coll_q;

    assign acc_a    = we_a | re_a;
    assign acc_b    = we_b | re_b;
    assign coll_hit = we_a & we_b & (adr_a == adr_b) & (|(be_a & be_b));

    // Port B lanes are scheduled first so port A overrides them on a same-address write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (we_b && be_b[i])
                ram_q[adr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (we_a && be_a[i])
                ram_q[adr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Only the port's own write data is forwarded; the other port always sees pre-write contents.
    always_comb begin
        rdata_a_d = ram_q[adr_a];
        rdata_b_d = ram_q[adr_b];
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (RDW_MODE == 0 && we_a && be_a[i])
                rdata_a_d[i*BYTE_WIDTH +: BYTE_WIDTH] = d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (RDW_MODE == 0 && we_b && be_b[i])
                rdata_b_d[i*BYTE_WIDTH +: BYTE_WIDTH] = d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a_q <= '0;
            q1_b_q <= '0;
            v1_a_q <= 1'b0;
            v1_b_q <= 1'b0;
        end else begin
            v1_a_q <= acc_a;
            v1_b_q <= acc_b;
            if (acc_a) q1_a_q <= rdata_a_d;
            if (acc_b) q1_b_q <= rdata_b_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a_q, q2_b_q;
            logic                  v2_a_q, v2_b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_a_q <= '0;
                    q2_b_q <= '0;
                    v2_a_q <= 1'b0;
                    v2_b_q <= 1'b0;
                end else begin
                    v2_a_q <= v1_a_q;
                    v2_b_q <= v1_b_q;
                    if (v1_a_q) q2_a_q <= q1_a_q;
                    if (v1_b_q) q2_b_q <= q1_b_q;
                end
            end
            assign q_a   = q2_a_q;
            assign q_b   = q2_b_q;
            assign vld_a = v2_a_q;
            assign vld_b = v2_b_q;
        end else begin : g_no_out_reg
            assign q_a   = q1_a_q;
            assign q_b   = q1_b_q;
            assign vld_a = v1_a_q;
            assign vld_b = v1_b_q;
        end
    endgenerate

    // A fresh collision takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        coll_q <= 1'b0;
        else if (coll_hit) coll_q <= 1'b1;
        else if (coll_clr) coll_q <= 1'b0;
    end

    assign coll = coll_q;

`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (coll_clr)
            cnt_q <= CNT_WIDTH'(coll_hit);
        else if (coll_hit && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign coll_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_versatile_fifo_dual_port_ram_sc_be.sv
// Bench for versatile_fifo_dual_port_ram_sc_be: three configurations share one stimulus stream
// (write-first, read-first, write-first with output register) and are checked against a word-level model.
module tb_versatile_fifo_dual_port_ram_sc_be;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] d_a, d_b;
    logic [BW-1:0] be_a, be_b;
    logic [AW-1:0] adr_a, adr_b;
    logic          we_a, re_a, we_b, re_b, coll_clr;
    logic [DW-1:0] q_a [3];
    logic [DW-1:0] q_b [3];
    logic          vld_a [3];
    logic          vld_b [3];
    logic          coll [3];
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
    logic [CW-1:0] coll_cnt [3];
`endif

    always #5 clk = ~clk;

    versatile_fifo_dual_port_ram_sc_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
        .RDW_MODE(0), .OUT_REG(0), .CNT_WIDTH(CW)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .d_a(d_a), .be_a(be_a), .adr_a(adr_a), .we_a(we_a), .re_a(re_a), .q_a(q_a[0]), .vld_a(vld_a[0]),
        .d_b(d_b), .be_b(be_b), .adr_b(adr_b), .we_b(we_b), .re_b(re_b), .q_b(q_b[0]), .vld_b(vld_b[0]),
        .coll(coll[0]), .coll_clr(coll_clr)
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt[0])
`endif
    );

    versatile_fifo_dual_port_ram_sc_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
        .RDW_MODE(1), .OUT_REG(0), .CNT_WIDTH(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .d_a(d_a), .be_a(be_a), .adr_a(adr_a), .we_a(we_a), .re_a(re_a), .q_a(q_a[1]), .vld_a(vld_a[1]),
        .d_b(d_b), .be_b(be_b), .adr_b(adr_b), .we_b(we_b), .re_b(re_b), .q_b(q_b[1]), .vld_b(vld_b[1]),
        .coll(coll[1]), .coll_clr(coll_clr)
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt[1])
`endif
    );

    versatile_fifo_dual_port_ram_sc_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
        .RDW_MODE(0), .OUT_REG(1), .CNT_WIDTH(CW)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .d_a(d_a), .be_a(be_a), .adr_a(adr_a), .we_a(we_a), .re_a(re_a), .q_a(q_a[2]), .vld_a(vld_a[2]),
        .d_b(d_b), .be_b(be_b), .adr_b(adr_b), .we_b(we_b), .re_b(re_b), .q_b(q_b[2]), .vld_b(vld_b[2]),
        .coll(coll[2]), .coll_clr(coll_clr)
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
        , .coll_cnt(coll_cnt[2])
`endif
    );

    // Reference model: memory image plus the expected visible outputs of each configuration.
    logic [DW-1:0] mem_m [16];
    logic [DW-1:0] e_q_a [3];
    logic [DW-1:0] e_q_b [3];
    logic          e_v_a [3];
    logic          e_v_b [3];
    logic [DW-1:0] s1_q_a, s1_q_b;
    logic          s1_v_a, s1_v_b;
    logic          e_coll;
    int            e_cnt;
    int            tests_run = 0;
    int            tests_failed = 0;
    bit            init_phase = 1'b0;

    typedef struct {
        logic          we_a, re_a;
        logic [AW-1:0] adr_a;
        logic [DW-1:0] d_a;
        logic [BW-1:0] be_a;
        logic          we_b, re_b;
        logic [AW-1:0] adr_b;
        logic [DW-1:0] d_b;
        logic [BW-1:0] be_b;
        logic          clr;
        logic [DW-1:0] x_q_a, x_q_b;
        logic          x_vld_a, x_vld_b, x_coll;
    } vec_t;

    vec_t vt [15];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] en);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++)
            if (en[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            e_q_a[k] = '0;
            e_q_b[k] = '0;
            e_v_a[k] = 1'b0;
            e_v_b[k] = 1'b0;
        end
        s1_q_a = '0;
        s1_q_b = '0;
        s1_v_a = 1'b0;
        s1_v_b = 1'b0;
        e_coll = 1'b0;
        e_cnt  = 0;
    endtask

    task automatic model_step();
        logic [DW-1:0] old_a, old_b, new_a, new_b;
        logic          acc_a, acc_b, hit;
        old_a = mem_m[adr_a];
        old_b = mem_m[adr_b];
        new_a = merge(old_a, d_a, we_a ? be_a : '0);
        new_b = merge(old_b, d_b, we_b ? be_b : '0);
        acc_a = we_a | re_a;
        acc_b = we_b | re_b;
        // output-register configuration presents what was read one access earlier
        if (s1_v_a) e_q_a[2] = s1_q_a;
        if (s1_v_b) e_q_b[2] = s1_q_b;
        e_v_a[2] = s1_v_a;
        e_v_b[2] = s1_v_b;
        if (acc_a) begin
            s1_q_a = new_a;
            e_q_a[0] = new_a;
            e_q_a[1] = old_a;
        end
        if (acc_b) begin
            s1_q_b = new_b;
            e_q_b[0] = new_b;
            e_q_b[1] = old_b;
        end
        s1_v_a = acc_a;
        s1_v_b = acc_b;
        e_v_a[0] = acc_a;  e_v_a[1] = acc_a;
        e_v_b[0] = acc_b;  e_v_b[1] = acc_b;
        if (we_b) mem_m[adr_b] = merge(mem_m[adr_b], d_b, be_b);
        if (we_a) mem_m[adr_a] = merge(mem_m[adr_a], d_a, be_a);
        hit = we_a && we_b && adr_a == adr_b && (be_a & be_b) != 0;
        if (coll_clr)   e_cnt = hit ? 1 : 0;
        else if (hit)   e_cnt = (e_cnt == (1 << CW) - 1) ? e_cnt : e_cnt + 1;
        e_coll = hit | (e_coll & ~coll_clr);
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            if (!(init_phase && k == 1)) begin
                check($sformatf("q_a[%0d]", k), q_a[k], e_q_a[k]);
                check($sformatf("q_b[%0d]", k), q_b[k], e_q_b[k]);
            end
            check($sformatf("vld_a[%0d]", k), DW'(vld_a[k]), DW'(e_v_a[k]));
            check($sformatf("vld_b[%0d]", k), DW'(vld_b[k]), DW'(e_v_b[k]));
            check($sformatf("coll[%0d]", k), DW'(coll[k]), DW'(e_coll));
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
            check($sformatf("coll_cnt[%0d]", k), DW'(coll_cnt[k]), DW'(e_cnt));
`endif
        end
    endtask

    task automatic drive(input logic wa, input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic [BW-1:0] ba, input logic wb, input logic rb, input logic [AW-1:0] ab,
                         input logic [DW-1:0] db, input logic [BW-1:0] bb, input logic clr);
        we_a = wa;  re_a = ra;  adr_a = aa;  d_a = da;  be_a = ba;
        we_b = wb;  re_b = rb;  adr_b = ab;  d_b = db;  be_b = bb;
        coll_clr = clr;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        we_a = 0; re_a = 0; adr_a = '0; d_a = '0; be_a = '0;
        we_b = 0; re_b = 0; adr_b = '0; d_b = '0; be_b = '0;
        coll_clr = 0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear without an edge.
    task automatic mid_reset();
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1,0,3,32'h11223344,4'hF, 0,0,0,32'h0,4'h0, 0, 32'h11223344,32'h00000000, 1,0,0};
        vt[1]  = '{0,1,3,32'h0,4'h0,        0,0,0,32'h0,4'h0, 0, 32'h11223344,32'h00000000, 1,0,0};
        vt[2]  = '{0,0,0,32'h0,4'h0,        1,0,3,32'hAABBCCDD,4'h5, 0, 32'h11223344,32'h11BB33DD, 0,1,0};
        vt[3]  = '{0,1,3,32'h0,4'h0,        0,0,0,32'h0,4'h0, 0, 32'h11BB33DD,32'h11BB33DD, 1,0,0};
        vt[4]  = '{1,0,7,32'h01020304,4'hF, 0,0,0,32'h0,4'h0, 0, 32'h01020304,32'h11BB33DD, 1,0,0};
        vt[5]  = '{1,0,7,32'hDEADBEEF,4'hF, 0,1,7,32'h0,4'h0, 0, 32'hDEADBEEF,32'h01020304, 1,1,0};
        vt[6]  = '{0,0,0,32'h0,4'h0,        0,1,7,32'h0,4'h0, 0, 32'hDEADBEEF,32'hDEADBEEF, 0,1,0};
        vt[7]  = '{1,0,5,32'h12345678,4'hF, 0,0,0,32'h0,4'h0, 0, 32'h12345678,32'hDEADBEEF, 1,0,0};
        vt[8]  = '{1,0,5,32'hFFFFFFFF,4'h3, 1,0,5,32'h00000000,4'h6, 0, 32'h1234FFFF,32'h12000078, 1,1,1};
        vt[9]  = '{0,0,0,32'h0,4'h0,        0,1,5,32'h0,4'h0, 0, 32'h1234FFFF,32'h1200FFFF, 0,1,1};
        vt[10] = '{0,0,0,32'h0,4'h0,        0,0,0,32'h0,4'h0, 1, 32'h1234FFFF,32'h1200FFFF, 0,0,0};
        vt[11] = '{1,0,5,32'h000000AA,4'h1, 1,0,5,32'h000000BB,4'h1, 0, 32'h1200FFAA,32'h1200FFBB, 1,1,1};
        vt[12] = '{1,0,5,32'h00001100,4'h2, 1,0,5,32'h00002200,4'h2, 1, 32'h120011AA,32'h120022AA, 1,1,1};
        vt[13] = '{0,0,0,32'h0,4'h0,        0,0,0,32'h0,4'h0, 1, 32'h120011AA,32'h120022AA, 0,0,0};
        vt[14] = '{0,1,5,32'h0,4'h0,        0,1,3,32'h0,4'h0, 0, 32'h120011AA,32'h11BB33DD, 1,1,0};

        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word so later reads never depend on uninitialised storage.
        init_phase = 1'b1;
        for (int a = 0; a < 16; a++)
            drive(1, 0, AW'(a), $urandom, 4'hF, 0, 0, '0, '0, '0, 0);
        mid_reset();
        init_phase = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].we_a, vt[i].re_a, vt[i].adr_a, vt[i].d_a, vt[i].be_a,
                  vt[i].we_b, vt[i].re_b, vt[i].adr_b, vt[i].d_b, vt[i].be_b, vt[i].clr);
            check($sformatf("tbl%0d q_a", i), q_a[0], vt[i].x_q_a);
            check($sformatf("tbl%0d q_b", i), q_b[0], vt[i].x_q_b);
            check($sformatf("tbl%0d vld_a", i), DW'(vld_a[0]), DW'(vt[i].x_vld_a));
            check($sformatf("tbl%0d vld_b", i), DW'(vld_b[0]), DW'(vt[i].x_vld_b));
            check($sformatf("tbl%0d coll", i), DW'(coll[0]), DW'(vt[i].x_coll));
        end

        for (int i = 0; i < 5; i++)
            drive(1, 0, 9, $urandom, 4'hF, 1, 0, 9, $urandom, 4'h1, 0);
        check("coll after 5 hits", DW'(coll[0]), 1);
`ifdef VERSATILE_FIFO_RAM_COLL_CNT_EN
        check("coll_cnt saturated", DW'(coll_cnt[0]), 3);
`endif
        mid_reset();
        check("rst q_a dut2", q_a[2], 0);
        check("rst coll dut0", DW'(coll[0]), 0);

        // Back-to-back reads stream through the output-register build.
        for (int a = 0; a < 4; a++)
            drive(0, 1, AW'(a), '0, '0, 0, 0, '0, '0, '0, 0);
        check("oreg q_a lags by one", q_a[2], mem_m[2]);
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
        check("oreg q_a last", q_a[2], mem_m[3]);
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
        check("oreg vld drops", DW'(vld_a[2]), 0);

        for (int n = 0; n < 400; n++)
            drive(1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), $urandom, BW'($urandom),
                  1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)), $urandom, BW'($urandom),
                  $urandom_range(0, 7) == 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
